rle_encoder: RTL

Streaming run-length encoder that converts a raster pixel stream into (pixel, run-count) pairs. It is the transmit-side counterpart of `rle_decoder`: its output pairs map directly onto the decoder's `data_in`/`count_in`/`valid_in` inputs. It sits between the frame source (camera/BRAM reader) and the compressed-frame buffer or link, and it applies backpressure on both sides through valid/ready handshakes.

---
 rtl/rle_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rle_encoder.sv
// Streaming run-length encoder: pixel stream in, (pixel, count) pairs out, valid/ready on both sides.
// Define RLE_ENCODER_STATS_EN to add the stat_pixels / stat_pairs counters.
module rle_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pixel_in,
  input  logic                   valid_in,
  input  logic                   last_in,
  output logic                   ready_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   valid_out,
  output logic                   last_out,
  input  logic                   ready_out,
  output logic                   done
`ifdef RLE_ENCODER_STATS_EN
  ,
  output logic [31:0]            stat_pixels,
  output logic [31:0]            stat_pairs
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] MAX_RUN = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  run_pix;
  logic [COUNT_WIDTH-1:0] run_cnt;
  logic                   run_active;
  logic                   slot_free;
  logic                   accept;
  logic                   pair_taken;

  assign slot_free  = !valid_out || ready_out;
  assign ready_in   = (state == RUN) && slot_free;
  assign accept     = valid_in && ready_in;
  assign pair_taken = valid_out && ready_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      run_pix    <= '0;
      run_cnt    <= '0;
      run_active <= 1'b0;
      data_out   <= '0;
      count_out  <= '0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Slot empties when taken; a load below in the same cycle refills it with no bubble.
      if (pair_taken) valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            run_active <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (!run_active) begin
              run_pix    <= pixel_in;
              run_cnt    <= ONE;
              run_active <= 1'b1;
            end else if (pixel_in == run_pix && run_cnt != MAX_RUN) begin
              run_cnt <= run_cnt + ONE;
            end else begin
              valid_out <= 1'b1;
              data_out  <= run_pix;
              count_out <= run_cnt;
              last_out  <= 1'b0;
              run_pix   <= pixel_in;
              run_cnt   <= ONE;
            end
            if (last_in) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            valid_out <= 1'b1;
            data_out  <= run_pix;
            count_out <= run_cnt;
            last_out  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (pair_taken && last_out) begin
            done       <= 1'b1;
            run_active <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RLE_ENCODER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pixels <= '0;
      stat_pairs  <= '0;
    end else if (state == IDLE && start) begin
      stat_pixels <= '0;
      stat_pairs  <= '0;
    end else begin
      if (accept && stat_pixels != '1)    stat_pixels <= stat_pixels + 32'd1;
      if (pair_taken && stat_pairs != '1) stat_pairs  <= stat_pairs + 32'd1;
    end
  end
`endif

endmodule
